window_5x5_gen: RTL and testbench

- Raster-scan pixel stream in; 5x5 neighbourhood window out, presented as 25 parallel taps od00..od24.
- Sits directly upstream of the 25-input sorting network and feeds its id00..id24 inputs.
- Built from 4 line buffers plus a 5x5 shift-register window.
- out_vld marks windows that lie fully inside the frame.

---
 rtl/window_5x5_gen.sv | 126 ++++++++++++
 tb/tb_window_5x5_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/window_5x5_gen.sv
// 5x5 sliding window generator for a raster-scan pixel stream.
// Four cascaded line buffers feed the rightmost column of a 5x5 shift-register window.
module window_5x5_gen #(
  parameter int DSIZE  = 8,
  parameter int LINE_W = 64,
  parameter int AW     = $clog2(LINE_W)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             in_sof,
  input  logic [DSIZE-1:0] in_data,
  output logic             out_vld,
  output logic [DSIZE-1:0] od00, od01, od02, od03, od04,
  output logic [DSIZE-1:0] od05, od06, od07, od08, od09,
  output logic [DSIZE-1:0] od10, od11, od12, od13, od14,
  output logic [DSIZE-1:0] od15, od16, od17, od18, od19,
  output logic [DSIZE-1:0] od20, od21, od22, od23, od24
);

  localparam logic [AW-1:0] LAST_COL = AW'(LINE_W - 1);

  logic [AW-1:0]    r_col;
  logic [2:0]       r_row;
  logic             r_out_vld;
  logic [DSIZE-1:0] r_lb0 [LINE_W];
  logic [DSIZE-1:0] r_lb1 [LINE_W];
  logic [DSIZE-1:0] r_lb2 [LINE_W];
  logic [DSIZE-1:0] r_lb3 [LINE_W];
  logic [DSIZE-1:0] r_win [5][5];

  logic [AW-1:0]    w_col;
  logic [2:0]       w_row;
  logic             w_last;
  logic             w_inside;
  logic [DSIZE-1:0] w_colv [5];

  // A start-of-frame pixel is (0,0) regardless of where the counters stand.
  assign w_col    = in_sof ? {AW{1'b0}} : r_col;
  assign w_row    = in_sof ? 3'd0 : r_row;
  assign w_last   = (w_col == LAST_COL);
  assign w_inside = (w_row >= 3'd4) && (w_col >= AW'(4));

  assign w_colv[0] = r_lb3[w_col];
  assign w_colv[1] = r_lb2[w_col];
  assign w_colv[2] = r_lb1[w_col];
  assign w_colv[3] = r_lb0[w_col];
  assign w_colv[4] = in_data;

  // Column/row position of the next pixel; row saturates at 4.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_col <= {AW{1'b0}};
      r_row <= 3'd0;
    end else if (in_vld) begin
      if (w_last) begin
        r_col <= {AW{1'b0}};
        r_row <= (w_row >= 3'd4) ? 3'd4 : (w_row + 3'd1);
      end else begin
        r_col <= w_col + AW'(1);
        r_row <= w_row;
      end
    end
  end

  // Line-buffer cascade; reads above see the pre-write contents. Not reset, row/col gating masks stale data.
  always_ff @(posedge clock) begin
    if (in_vld && !rst) begin
      r_lb0[w_col] <= in_data;
      r_lb1[w_col] <= r_lb0[w_col];
      r_lb2[w_col] <= r_lb1[w_col];
      r_lb3[w_col] <= r_lb2[w_col];
    end
  end

  // Window shift register and valid flag.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int rr = 0; rr < 5; rr++) begin
        for (int cc = 0; cc < 5; cc++) begin
          r_win[rr][cc] <= {DSIZE{1'b0}};
        end
      end
      r_out_vld <= 1'b0;
    end else if (in_vld) begin
      for (int rr = 0; rr < 5; rr++) begin
        for (int cc = 0; cc < 4; cc++) begin
          r_win[rr][cc] <= r_win[rr][cc+1];
        end
        r_win[rr][4] <= w_colv[rr];
      end
      r_out_vld <= w_inside;
    end else begin
      r_out_vld <= 1'b0;
    end
  end

  assign out_vld = r_out_vld;

  assign od00 = r_win[0][0];
  assign od01 = r_win[0][1];
  assign od02 = r_win[0][2];
  assign od03 = r_win[0][3];
  assign od04 = r_win[0][4];
  assign od05 = r_win[1][0];
  assign od06 = r_win[1][1];
  assign od07 = r_win[1][2];
  assign od08 = r_win[1][3];
  assign od09 = r_win[1][4];
  assign od10 = r_win[2][0];
  assign od11 = r_win[2][1];
  assign od12 = r_win[2][2];
  assign od13 = r_win[2][3];
  assign od14 = r_win[2][4];
  assign od15 = r_win[3][0];
  assign od16 = r_win[3][1];
  assign od17 = r_win[3][2];
  assign od18 = r_win[3][3];
  assign od19 = r_win[3][4];
  assign od20 = r_win[4][0];
  assign od21 = r_win[4][1];
  assign od22 = r_win[4][2];
  assign od23 = r_win[4][3];
  assign od24 = r_win[4][4];

endmodule

// File: tb/tb_window_5x5_gen.sv
// Directed self-checking bench for window_5x5_gen with LINE_W=8.
// Ramp frames use pixel value row*8+col so every expected tap follows from its position.
module tb_window_5x5_gen;

  localparam int LW = 8;

  logic       clock = 1'b0;
  logic       rst;
  logic       in_vld;
  logic       in_sof;
  logic [7:0] in_data;
  logic       out_vld;
  logic [7:0] od00, od01, od02, od03, od04, od05, od06, od07, od08, od09;
  logic [7:0] od10, od11, od12, od13, od14, od15, od16, od17, od18, od19;
  logic [7:0] od20, od21, od22, od23, od24;
  logic [199:0] w_vec;
  logic [199:0] last_exp;

  int n_chk   = 0;
  int n_pass  = 0;
  int n_pulse = 0;

  window_5x5_gen #(.DSIZE(8), .LINE_W(LW)) dut (
    .clock(clock), .rst(rst), .in_vld(in_vld), .in_sof(in_sof), .in_data(in_data),
    .out_vld(out_vld),
    .od00(od00), .od01(od01), .od02(od02), .od03(od03), .od04(od04),
    .od05(od05), .od06(od06), .od07(od07), .od08(od08), .od09(od09),
    .od10(od10), .od11(od11), .od12(od12), .od13(od13), .od14(od14),
    .od15(od15), .od16(od16), .od17(od17), .od18(od18), .od19(od19),
    .od20(od20), .od21(od21), .od22(od22), .od23(od23), .od24(od24)
  );

  assign w_vec = {od24, od23, od22, od21, od20, od19, od18, od17, od16, od15,
                  od14, od13, od12, od11, od10, od09, od08, od07, od06, od05,
                  od04, od03, od02, od01, od00};

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Expected window for a ramp frame after pixel (r,c).
  function automatic logic [199:0] ramp_win(input int r, input int c);
    logic [199:0] v;
    v = '0;
    for (int rr = 0; rr < 5; rr++)
      for (int cc = 0; cc < 5; cc++)
        v[(rr*5+cc)*8 +: 8] = 8'((r - 4 + rr) * 8 + (c - 4 + cc));
    return v;
  endfunction

  function automatic logic [199:0] fill_win(input logic [7:0] b);
    return {25{b}};
  endfunction

  // Send one accepted pixel and check the window it produces; kind 0 = ramp, 1 = constant fill.
  task automatic px(input int r, input int c, input logic sof, input logic [7:0] d, input int kind);
    logic exp_v;
    logic [199:0] exp;
    @(negedge clock);
    in_vld = 1'b1; in_sof = sof; in_data = d;
    @(posedge clock); #1;
    exp_v = (r >= 4) && (c >= 4);
    chk($sformatf("vld_r%0d_c%0d", r, c), 200'(out_vld), 200'(exp_v));
    if (out_vld) n_pulse++;
    if (exp_v) begin
      exp = (kind == 0) ? ramp_win(r, c) : fill_win(d);
      chk($sformatf("win_r%0d_c%0d", r, c), w_vec, exp);
      last_exp = exp;
    end
    if (kind == 0 && r == 4 && c == 4) begin
      chk("od00_at_4_4", 200'(od00), 200'(8'd0));
      chk("od04_at_4_4", 200'(od04), 200'(8'd4));
      chk("od12_at_4_4", 200'(od12), 200'(8'd18));
      chk("od20_at_4_4", 200'(od20), 200'(8'd32));
      chk("od24_at_4_4", 200'(od24), 200'(8'd36));
    end
    if (kind == 0 && r == 5 && c == 4) begin
      chk("od24_at_5_4", 200'(od24), 200'(8'd44));
      chk("od00_at_5_4", 200'(od00), 200'(8'd8));
    end
  endtask

  task automatic idle(input logic check_hold);
    @(negedge clock);
    in_vld = 1'b0; in_sof = 1'b0; in_data = 8'h5A;
    @(posedge clock); #1;
    chk("idle_vld", 200'(out_vld), 200'(1'b0));
    if (check_hold) chk("idle_hold", w_vec, last_exp);
  endtask

  // Ramp pixels in raster order; optional idle cycle after each one.
  task automatic ramp_pixels(input int n_pix, input logic sof_first, input int off, input logic toggle);
    for (int i = 0; i < n_pix; i++) begin
      px(i / LW, i % LW, sof_first && (i == 0), 8'((i / LW) * 8 + (i % LW) + off), 0);
      if (toggle) idle((i / LW >= 4) && (i % LW >= 4));
    end
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_sof = 1'b0; in_data = 8'h00;
    last_exp = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_vld", 200'(out_vld), 200'(1'b0));
    chk("reset_win", w_vec, 200'(0));
    @(negedge clock); rst = 1'b0;

    // Continuous 6-line ramp frame.
    n_pulse = 0;
    ramp_pixels(6 * LW, 1'b1, 0, 1'b0);
    chk("pulses_cont", 200'(n_pulse), 200'(8));

    // Same frame with in_vld toggling.
    n_pulse = 0;
    ramp_pixels(6 * LW, 1'b1, 0, 1'b1);
    chk("pulses_toggle", 200'(n_pulse), 200'(8));

    // Reset mid line 5 with in_vld high, then a 5-line frame without in_sof.
    ramp_pixels(5 * LW + 3, 1'b1, 0, 1'b0);
    @(negedge clock);
    rst = 1'b1; in_vld = 1'b1; in_sof = 1'b0; in_data = 8'hAA;
    @(posedge clock); #1;
    chk("rst_mid_vld", 200'(out_vld), 200'(1'b0));
    chk("rst_mid_win", w_vec, 200'(0));
    @(negedge clock); rst = 1'b0; in_vld = 1'b0;
    n_pulse = 0;
    ramp_pixels(5 * LW, 1'b0, 0, 1'b0);
    chk("pulses_after_rst", 200'(n_pulse), 200'(4));

    // in_sof reasserted at pixel (4,2): old data offset by 100, then a fresh frame.
    n_pulse = 0;
    ramp_pixels(4 * LW + 2, 1'b1, 100, 1'b0);
    ramp_pixels(5 * LW, 1'b1, 0, 1'b0);
    chk("pulses_resof", 200'(n_pulse), 200'(4));

    // Back-to-back frames: all ones then all zeros.
    n_pulse = 0;
    for (int i = 0; i < 5 * LW; i++) px(i / LW, i % LW, i == 0, 8'hFF, 1);
    for (int i = 0; i < 5 * LW; i++) px(i / LW, i % LW, i == 0, 8'h00, 1);
    chk("pulses_b2b", 200'(n_pulse), 200'(8));

    idle(1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
